execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- LC-3 pipeline execute stage, directly downstream of decode; consumes decode_out bus (ir, e_control, npc_out, mem_control, w_control) plus register-file read values.
- Computes ALU result and effective/branch address; registers results into the execute→writeback/memory latch under enable_execute.
- Drives combinational source-register indices back to the register file.

Parameters:
- DATA_W, 16, datapath width (IR, PC, data)
- REG_AW, 3, register index width

Ports:
- clock  in  1  stage clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable_execute  in  1  latch enable; outputs hold when 0
- ir  in  16  instruction from decode
- e_control  in  6  {alu_op[5:4], pcselect1[3:2], pcselect2[1], op2select[0]}
- npc_in  in  16  next PC from decode (npc_out)
- mem_control_in  in  1  memory control from decode
- w_control_in  in  2  writeback control from decode
- vsr1  in  16  register-file value for sr1
- vsr2  in  16  register-file value for sr2
- bypass_alu_1, bypass_alu_2  in  1  forward own aluout into op1/op2
- bypass_mem_1, bypass_mem_2  in  1  forward mem_bypass_val into op1/op2
- mem_bypass_val  in  16  forwarded memory-stage data
- aluout  out  16  registered ALU/address result
- pcout  out  16  registered address-adder result
- m_data  out  16  registered store data (operand 2 after bypass)
- dr  out  3  registered destination, ir[11:9]
- nzp  out  3  registered branch condition mask
- ir_exec  out  16  registered ir
- mem_control_out  out  1  registered mem_control_in
- w_control_out  out  2  registered w_control_in
- sr1  out  3  combinational, ir[8:6]
- sr2  out  3  combinational; ir[11:9] for ST/STI/STR (opcodes 0011/1011/0111), else ir[2:0]

Behaviour:
- Reset (reset==0, async): all registered outputs 16'h0/3'b0/2'b0/1'b0; held until reset deasserts.
- Latency 1 cycle: rising edge with enable_execute==1 captures results; enable_execute==0 holds all registered outputs unchanged.
- op1 = vsr1; op2 = op2select ? vsr2 : sext(ir[4:0]).
- Bypass (feature enabled): op1 = bypass_alu_1 ? aluout : bypass_mem_1 ? mem_bypass_val : vsr1; op2/m_data base likewise with *_2 (alu priority over mem). Bypass replaces vsr2 before the op2select mux; imm5 is never bypassed.
- Offset by pcselect1: 00 sext(ir[10:0]), 01 sext(ir[8:0]), 10 sext(ir[5:0]), 11 zero.
- Base by pcselect2: 1 npc_in, 0 op1. pcout_next = base + offset, mod 2^16 (wrap, no carry out).
- alu_op: 00 ADD op1+op2 (mod 2^16); 01 AND op1&op2; 10 NOT ~op1; 11 pass, aluout_next = pcout_next (LEA/LD/ST address).
- nzp_next: opcode 0000 (BR) → ir[11:9]; opcode 1100 (JMP) → 3'b111; otherwise 3'b000.
- m_data_next = bypassed vsr2.
- Simultaneous bypass_alu_x and bypass_mem_x: alu wins.
- Reset mid-operation overrides enable_execute.

Optional Feature:
- EXECUTE_BYPASS_EN defined: forwarding muxes present as above.
- Not defined: bypass_* and mem_bypass_val ports remain but are ignored; op1=vsr1, vsr2 used directly.

Decomposition:
- Package execute_pkg: alu_op enum (ALU_ADD, ALU_AND, ALU_NOT, ALU_PASS), pcselect1 constants, opcode constants (OP_BR, OP_JMP, OP_ST, OP_STI, OP_STR), sext helper functions.
- Sub-module execute_alu: combinational ALU + address adder; execute_stage holds muxes, bypass, and output registers.

Test Plan:
- ADD reg: ir=16'h1042, e_control=6'b001101, vsr1=5, vsr2=7, enable=1 → next cycle aluout=16'h000C, dr=0, nzp=0; sr1=1, sr2=2 combinationally.
- ADD imm negative: ir=16'h107F, e_control=6'b001100, vsr1=16'h0003 → aluout=16'h0002; vsr1=16'hFFFF, ir=16'h1065 → aluout=16'h0004 (wrap).
- BR: ir=16'h0E05, e_control=6'b110110, npc_in=16'h3001 → pcout=aluout=16'h3006, nzp=3'b111; npc_in=16'hFFFF, offset +5 → 16'h0004.
- Store: ir=16'h3A00 (ST R5), vsr2=16'hBEEF → sr2=5, m_data=16'hBEEF; enable_execute=0 next cycle with new inputs → all outputs unchanged.
- Bypass (EXECUTE_BYPASS_EN): prior aluout=16'h0010, bypass_alu_1=1, bypass_mem_1=1, mem_bypass_val=16'h0100, ADD reg vsr2=1 → aluout=16'h0011; macro undefined → vsr1 used.
- Async reset asserted mid-cycle with enable=1 → all outputs zero immediately, stay zero until reset=1 and next enabled edge.

Source files
------------

// File: rtl/execute_pkg.sv
// execute_pkg: shared types, field encodings and sign-extension helper for the LC-3 execute stage.
package execute_pkg;
  localparam int XLEN = 16;
  typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_NOT, ALU_PASS} alu_op_e;
  localparam logic [1:0] PCS1_OFF11 = 2'b00;
  localparam logic [1:0] PCS1_OFF9  = 2'b01;
  localparam logic [1:0] PCS1_OFF6  = 2'b10;
  localparam logic [1:0] PCS1_ZERO  = 2'b11;
  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_STR = 4'b0111;
  function automatic logic [XLEN-1:0] sext(input logic [XLEN-1:0] v, input int unsigned bits);
    logic [XLEN-1:0] m;
    m = {XLEN{1'b1}} << bits;
    return v[bits-1] ? (v | m) : (v & ~m);
  endfunction
endpackage

// File: rtl/execute_alu.sv
// execute_alu: combinational ALU and address adder; PASS forwards the computed address.
module execute_alu
  import execute_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  alu_op_e             alu_op,
  input  logic [DATA_W-1:0]   op1,
  input  logic [DATA_W-1:0]   op2,
  input  logic [DATA_W-1:0]   base,
  input  logic [DATA_W-1:0]   offset,
  output logic [DATA_W-1:0]   aluout,
  output logic [DATA_W-1:0]   pcout
);
  assign pcout  = base + offset;
  assign aluout = alu_op == ALU_ADD ? op1 + op2 :
                  alu_op == ALU_AND ? op1 & op2 :
                  alu_op == ALU_NOT ? ~op1 : pcout;
endmodule

// File: rtl/execute_stage.sv
// execute_stage: LC-3 execute stage with output latch; forwarding muxes only when EXECUTE_BYPASS_EN is defined.
module execute_stage
  import execute_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int REG_AW = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_execute,
  input  logic [15:0]       ir,
  input  logic [5:0]        e_control,
  input  logic [DATA_W-1:0] npc_in,
  input  logic              mem_control_in,
  input  logic [1:0]        w_control_in,
  input  logic [DATA_W-1:0] vsr1,
  input  logic [DATA_W-1:0] vsr2,
  input  logic              bypass_alu_1,
  input  logic              bypass_alu_2,
  input  logic              bypass_mem_1,
  input  logic              bypass_mem_2,
  input  logic [DATA_W-1:0] mem_bypass_val,
  output logic [DATA_W-1:0] aluout,
  output logic [DATA_W-1:0] pcout,
  output logic [DATA_W-1:0] m_data,
  output logic [REG_AW-1:0] dr,
  output logic [2:0]        nzp,
  output logic [15:0]       ir_exec,
  output logic              mem_control_out,
  output logic [1:0]        w_control_out,
  output logic [REG_AW-1:0] sr1,
  output logic [REG_AW-1:0] sr2
);
  logic [DATA_W-1:0] r_aluout, r_pcout, r_m_data;
  logic [REG_AW-1:0] r_dr;
  logic [2:0]        r_nzp;
  logic [15:0]       r_ir;
  logic              r_mem_control;
  logic [1:0]        r_w_control;
  logic [DATA_W-1:0] w_op1, w_vsr2, w_op2, w_offset, w_base, w_aluout, w_pcout;
  logic [2:0]        w_nzp;
  logic [3:0]        w_opcode;
  logic [1:0]        w_pcs1;
  assign w_opcode = ir[15:12];
  assign w_pcs1   = e_control[3:2];
  assign sr1 = ir[8:6];
  assign sr2 = (w_opcode == OP_ST || w_opcode == OP_STI || w_opcode == OP_STR) ? ir[11:9] : ir[2:0];
`ifdef EXECUTE_BYPASS_EN
  assign w_op1  = bypass_alu_1 ? r_aluout : bypass_mem_1 ? mem_bypass_val : vsr1;
  assign w_vsr2 = bypass_alu_2 ? r_aluout : bypass_mem_2 ? mem_bypass_val : vsr2;
`else
  logic w_unused_bypass;
  assign w_unused_bypass = ^{bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2, mem_bypass_val};
  assign w_op1  = vsr1;
  assign w_vsr2 = vsr2;
`endif
  // imm5 bypasses forwarding: only the register operand is replaced
  assign w_op2    = e_control[0] ? w_vsr2 : sext(XLEN'(ir[4:0]), 5);
  assign w_offset = w_pcs1 == PCS1_OFF11 ? sext(XLEN'(ir[10:0]), 11) :
                    w_pcs1 == PCS1_OFF9  ? sext(XLEN'(ir[8:0]), 9) :
                    w_pcs1 == PCS1_OFF6  ? sext(XLEN'(ir[5:0]), 6) : '0;
  assign w_base   = e_control[1] ? npc_in : w_op1;
  assign w_nzp    = w_opcode == OP_BR ? ir[11:9] : w_opcode == OP_JMP ? 3'b111 : 3'b000;
  execute_alu #(.DATA_W(DATA_W)) u_alu (
    .alu_op (alu_op_e'(e_control[5:4])),
    .op1    (w_op1),
    .op2    (w_op2),
    .base   (w_base),
    .offset (w_offset),
    .aluout (w_aluout),
    .pcout  (w_pcout)
  );
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_aluout      <= '0;
      r_pcout       <= '0;
      r_m_data      <= '0;
      r_dr          <= '0;
      r_nzp         <= '0;
      r_ir          <= '0;
      r_mem_control <= 1'b0;
      r_w_control   <= '0;
    end else if (enable_execute) begin
      r_aluout      <= w_aluout;
      r_pcout       <= w_pcout;
      r_m_data      <= w_vsr2;
      r_dr          <= ir[11:9];
      r_nzp         <= w_nzp;
      r_ir          <= ir;
      r_mem_control <= mem_control_in;
      r_w_control   <= w_control_in;
    end
  end
  assign aluout          = r_aluout;
  assign pcout           = r_pcout;
  assign m_data          = r_m_data;
  assign dr              = r_dr;
  assign nzp             = r_nzp;
  assign ir_exec         = r_ir;
  assign mem_control_out = r_mem_control;
  assign w_control_out   = r_w_control;
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed plan vectors plus randomized traffic against an integer reference model.
module tb_execute_stage;
  logic clock = 1'b0, reset = 1'b0, enable_execute = 1'b0;
  logic [15:0] ir = '0, npc_in = '0, vsr1 = '0, vsr2 = '0, mem_bypass_val = '0;
  logic [5:0] e_control = '0;
  logic mem_control_in = 1'b0, bypass_alu_1 = 1'b0, bypass_alu_2 = 1'b0, bypass_mem_1 = 1'b0, bypass_mem_2 = 1'b0;
  logic [1:0] w_control_in = '0;
  logic [15:0] aluout, pcout, m_data, ir_exec;
  logic [2:0] dr, nzp, sr1, sr2;
  logic mem_control_out;
  logic [1:0] w_control_out;
  int checks = 0, errors = 0;
  int e_alu, e_pc, e_md, e_dr, e_nzp, e_ir, e_mc, e_wc;

  execute_stage dut (
    .clock(clock), .reset(reset), .enable_execute(enable_execute), .ir(ir), .e_control(e_control),
    .npc_in(npc_in), .mem_control_in(mem_control_in), .w_control_in(w_control_in),
    .vsr1(vsr1), .vsr2(vsr2), .bypass_alu_1(bypass_alu_1), .bypass_alu_2(bypass_alu_2),
    .bypass_mem_1(bypass_mem_1), .bypass_mem_2(bypass_mem_2), .mem_bypass_val(mem_bypass_val),
    .aluout(aluout), .pcout(pcout), .m_data(m_data), .dr(dr), .nzp(nzp), .ir_exec(ir_exec),
    .mem_control_out(mem_control_out), .w_control_out(w_control_out), .sr1(sr1), .sr2(sr2)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sx(input int v, input int bits);
    return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
  endfunction

  task automatic model_reset();
    {e_alu, e_pc, e_md, e_dr, e_nzp, e_ir, e_mc, e_wc} = '0;
  endtask

  // Computes the architectural result of the current inputs from the ISA rules.
  task automatic model_exec();
    int op1, v2, op2, off, base, pc, alu, opc, fld;
    bit bp = 0;
`ifdef EXECUTE_BYPASS_EN
    bp = 1;
`endif
    op1 = (bp && bypass_alu_1) ? e_alu : (bp && bypass_mem_1) ? int'(mem_bypass_val) : int'(vsr1);
    v2  = (bp && bypass_alu_2) ? e_alu : (bp && bypass_mem_2) ? int'(mem_bypass_val) : int'(vsr2);
    op2 = e_control[0] ? v2 : (sx(ir & 31, 5) & 'hFFFF);
    fld = e_control[3:2];
    off = fld == 0 ? sx(ir & 'h7FF, 11) : fld == 1 ? sx(ir & 'h1FF, 9) : fld == 2 ? sx(ir & 'h3F, 6) : 0;
    base = e_control[1] ? int'(npc_in) : op1;
    pc = (base + off) & 'hFFFF;
    case (e_control[5:4])
      2'd0: alu = (op1 + op2) & 'hFFFF;
      2'd1: alu = op1 & op2;
      2'd2: alu = (~op1) & 'hFFFF;
      default: alu = pc;
    endcase
    opc = ir >> 12;
    e_alu = alu; e_pc = pc; e_md = v2; e_dr = (ir >> 9) & 7; e_ir = ir;
    e_nzp = opc == 0 ? ((ir >> 9) & 7) : opc == 12 ? 7 : 0;
    e_mc = mem_control_in; e_wc = w_control_in;
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".aluout"}, aluout, e_alu);
    check({tag, ".pcout"}, pcout, e_pc);
    check({tag, ".m_data"}, m_data, e_md);
    check({tag, ".dr"}, dr, e_dr);
    check({tag, ".nzp"}, nzp, e_nzp);
    check({tag, ".ir_exec"}, ir_exec, e_ir);
    check({tag, ".mem_ctl"}, mem_control_out, e_mc);
    check({tag, ".w_ctl"}, w_control_out, e_wc);
  endtask

  // Inputs are set #1 after a posedge; check comb indices, clock once, check latch.
  task automatic step(input string tag, input bit en);
    int opc;
    opc = ir >> 12;
    enable_execute = en;
    #1;
    check({tag, ".sr1"}, sr1, (ir >> 6) & 7);
    check({tag, ".sr2"}, sr2, (opc == 3 || opc == 11 || opc == 7) ? ((ir >> 9) & 7) : (ir & 7));
    if (en) model_exec();
    @(posedge clock);
    #1;
    check_outs(tag);
  endtask

  task automatic set_op(input logic [15:0] i, input logic [5:0] ec, input logic [15:0] a, input logic [15:0] b, input logic [15:0] npc);
    ir = i; e_control = ec; vsr1 = a; vsr2 = b; npc_in = npc;
    {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2} = '0;
  endtask

  initial begin
    model_reset();
    #2;
    check_outs("reset");
    @(posedge clock); #1;
    reset = 1'b1;
    set_op(16'h1042, 6'b001101, 16'd5, 16'd7, 16'h0);
    step("add_reg", 1);
    check("add_reg.val", aluout, 16'h000C);
    set_op(16'h107F, 6'b001100, 16'h0003, 16'h0, 16'h0);
    step("add_imm_neg", 1);
    check("add_imm_neg.val", aluout, 16'h0002);
    set_op(16'h1065, 6'b001100, 16'hFFFF, 16'h0, 16'h0);
    step("add_imm_wrap", 1);
    check("add_imm_wrap.val", aluout, 16'h0004);
    set_op(16'h0E05, 6'b110110, 16'h0, 16'h0, 16'h3001);
    step("br", 1);
    check("br.val", pcout, 16'h3006);
    set_op(16'h0E05, 6'b110110, 16'h0, 16'h0, 16'hFFFF);
    step("br_wrap", 1);
    check("br_wrap.val", pcout, 16'h0004);
    set_op(16'h3A00, 6'b110110, 16'h1234, 16'hBEEF, 16'h4000);
    mem_control_in = 1'b1; w_control_in = 2'b10;
    step("st", 1);
    check("st.val", m_data, 16'hBEEF);
    set_op(16'h5FFF, 6'b010101, 16'hAAAA, 16'h5555, 16'h1111);
    mem_control_in = 1'b0; w_control_in = 2'b01;
    step("hold", 0);
    check("hold.val", m_data, 16'hBEEF);
    set_op(16'hC1C0, 6'b101100, 16'h00F0, 16'h0, 16'h0);
    step("jmp_not", 1);
    set_op(16'h1060, 6'b001100, 16'h0010, 16'h0, 16'h0);
    step("pre_byp", 1);
    set_op(16'h1042, 6'b001101, 16'h0055, 16'h0001, 16'h0);
    bypass_alu_1 = 1'b1; bypass_mem_1 = 1'b1; mem_bypass_val = 16'h0100;
    step("bypass", 1);
`ifdef EXECUTE_BYPASS_EN
    check("bypass.val", aluout, 16'h0011);
`else
    check("bypass.val", aluout, 16'h0056);
`endif
    for (int n = 0; n < 300; n++) begin
      ir = 16'($urandom); e_control = 6'($urandom); npc_in = 16'($urandom);
      vsr1 = 16'($urandom); vsr2 = 16'($urandom); mem_bypass_val = 16'($urandom);
      {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2} = 4'($urandom);
      mem_control_in = 1'($urandom); w_control_in = 2'($urandom);
      step("rand", $urandom_range(0, 3) != 0);
    end
    set_op(16'h1042, 6'b001101, 16'd9, 16'd9, 16'h0);
    enable_execute = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_outs("async_rst");
    repeat (2) @(posedge clock);
    #1;
    check_outs("rst_hold");
    reset = 1'b1;
    #1;
    check_outs("rst_release");
    step("after_rst", 1);
    check("after_rst.val", aluout, 16'd18);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
